// File: rtl/noc_pkg.sv
// Shared helpers for the leaf router: port index constants, index-width helpers
// and extraction of the destination field from a flit.
package noc_pkg;

  localparam int LOCAL_IDX = 0;

  function automatic int idx_w(input int num_spines);
    return $clog2(num_spines + 1);
  endfunction

  function automatic int spine_w(input int num_spines);
    return $clog2(num_spines);
  endfunction

  // Destination field sits in the MSBs of the flit; flits are zero-extended to 128 bits.
  function automatic logic [31:0] dest_of(input logic [127:0] flit, input int dwidth,
                                          input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return 32'(flit >> (dwidth - addr_w)) & mask;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit buffer; pointers carry one extra wrap bit to tell full from empty.
module router_fifo #(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DWIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/leaf_router_cb.sv
// Leaf-tile router: buffered local + spine inputs, single-entry output stages,
// round-robin sharing of local_out, and counted discard of misrouted spine flits.
module leaf_router_cb
  import noc_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int ADDR_W     = 6,
  parameter int NUM_SPINES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCAL_ADDR = 27
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [DWIDTH-1:0]            local_in_data,
  input  logic                         local_in_valid,
  output logic                         local_in_ready,
  output logic [DWIDTH-1:0]            local_out_data,
  output logic                         local_out_valid,
  input  logic                         local_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [15:0]                  drop_count
);
  localparam int NUM_IN  = NUM_SPINES + 1;
  localparam int IDX_W   = idx_w(NUM_SPINES);
  localparam int SPINE_W = spine_w(NUM_SPINES);
  localparam logic [31:0] MY_ADDR = 32'(LOCAL_ADDR);

  logic [DWIDTH-1:0]  in_data_s [NUM_IN];
  logic [DWIDTH-1:0]  head_s    [NUM_IN];
  logic [NUM_IN-1:0]  in_valid_s, full_s, empty_s, push_s, pop_s;
  logic [NUM_IN-1:0]  is_local_s, req_s, drop_s;
  logic [NUM_SPINES-1:0] sp_load_s;
  logic [SPINE_W-1:0] tgt_s;
  logic               lo_load_s;
  logic [IDX_W-1:0]   grant_s, ptr_r;
  logic [DWIDTH-1:0]  grant_data_s;
  logic [16:0]        cnt_sum_s;
  logic [DWIDTH-1:0]  lo_data_r;
  logic               lo_valid_r;
  logic [NUM_SPINES*DWIDTH-1:0] sp_data_r;
  logic [NUM_SPINES-1:0]        sp_valid_r;
  logic [15:0]        drop_count_r;

  assign in_data_s[0]  = local_in_data;
  assign in_valid_s[0] = local_in_valid;
  assign local_in_ready = !full_s[0];

  for (genvar s = 0; s < NUM_SPINES; s++) begin : g_spine_in
    assign in_data_s[s+1]    = spine_in_data[s*DWIDTH +: DWIDTH];
    assign in_valid_s[s+1]   = spine_in_valid[s];
    assign spine_in_ready[s] = !full_s[s+1];
  end

  assign push_s = in_valid_s & ~full_s;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_fifo
    router_fifo #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (ACLK),
      .rst_n     (ARESETn),
      .push      (push_s[i]),
      .push_data (in_data_s[i]),
      .pop       (pop_s[i]),
      .head      (head_s[i]),
      .full      (full_s[i]),
      .empty     (empty_s[i])
    );
  end

  // Classify every head: local delivery request, or (spine only) discard.
  always_comb begin
    is_local_s = '0;
    req_s      = '0;
    drop_s     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      is_local_s[i] = (dest_of(128'(head_s[i]), DWIDTH, ADDR_W) == MY_ADDR);
      req_s[i]      = !empty_s[i] && is_local_s[i];
      drop_s[i]     = (i != LOCAL_IDX) && !empty_s[i] && !is_local_s[i];
    end
    tgt_s = SPINE_W'(dest_of(128'(head_s[LOCAL_IDX]), DWIDTH, ADDR_W));
    for (int s = 0; s < NUM_SPINES; s++) begin
      sp_load_s[s] = !empty_s[LOCAL_IDX] && !is_local_s[LOCAL_IDX] &&
                     (tgt_s == SPINE_W'(s)) && (!sp_valid_r[s] || spine_out_ready[s]);
    end
  end

  // Round-robin grant for local_out, searching upward from the pointer.
  always_comb begin
    lo_load_s    = 1'b0;
    grant_s      = '0;
    grant_data_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      int c;
      c = int'(ptr_r) + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (!lo_load_s && (!lo_valid_r || local_out_ready) && req_s[c]) begin
        lo_load_s    = 1'b1;
        grant_s      = IDX_W'(c);
        grant_data_s = head_s[c];
      end
    end
    pop_s = drop_s;
    pop_s[LOCAL_IDX] = (|sp_load_s) || (lo_load_s && (grant_s == IDX_W'(LOCAL_IDX)));
    for (int i = 1; i < NUM_IN; i++) begin
      if (lo_load_s && (grant_s == IDX_W'(i))) pop_s[i] = 1'b1;
    end
    cnt_sum_s = {1'b0, drop_count_r};
    for (int i = 1; i < NUM_IN; i++) begin
      cnt_sum_s = cnt_sum_s + {16'd0, drop_s[i]};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      lo_data_r    <= '0;
      lo_valid_r   <= 1'b0;
      ptr_r        <= '0;
      sp_data_r    <= '0;
      sp_valid_r   <= '0;
      drop_count_r <= 16'd0;
    end else begin
      if (lo_load_s) begin
        lo_data_r  <= grant_data_s;
        lo_valid_r <= 1'b1;
        ptr_r      <= (grant_s == IDX_W'(NUM_IN - 1)) ? '0 : grant_s + 1'b1;
      end else if (local_out_ready) begin
        lo_valid_r <= 1'b0;
      end
      for (int s = 0; s < NUM_SPINES; s++) begin
        if (sp_load_s[s]) begin
          sp_data_r[s*DWIDTH +: DWIDTH] <= head_s[LOCAL_IDX];
          sp_valid_r[s]                 <= 1'b1;
        end else if (spine_out_ready[s]) begin
          sp_valid_r[s] <= 1'b0;
        end
      end
      drop_count_r <= (cnt_sum_s > 17'h0FFFF) ? 16'hFFFF : cnt_sum_s[15:0];
    end
  end

  assign local_out_data  = lo_data_r;
  assign local_out_valid = lo_valid_r;
  assign spine_out_data  = sp_data_r;
  assign spine_out_valid = sp_valid_r;
  assign drop_count      = drop_count_r;

endmodule
